// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock.
// Define SERIAL_ADDER_SUB_EN to add the sub port (a - b).
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             sub_w;
  logic             s_bit;
  logic             c_nxt;
  logic             last;
  logic             accept;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_w = sub;
`else
  assign sub_w = 1'b0;
`endif

  assign s_bit  = a_sh[0] ^ b_sh[0] ^ carry;
  assign c_nxt  = (a_sh[0] & b_sh[0])
                | (a_sh[0] & carry)
                | (b_sh[0] & carry);
  assign last   = (cnt == LAST);
  assign accept = (state == S_IDLE) && start;

  assign busy = (state == S_SHIFT);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (start) state_n = S_SHIFT;
      S_SHIFT: if (last)  state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (accept) begin
      a_sh  <= a_in;
      b_sh  <= sub_w ? ~b_in : b_in;
      carry <= sub_w;
      cnt   <= '0;
    end else if (state == S_SHIFT) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= {s_bit, res_sh[WIDTH-1:1]};
      carry  <= c_nxt;
      cnt    <= cnt + 1'b1;
      if (last) begin
        sum  <= {s_bit, res_sh[WIDTH-1:1]};
        cout <= c_nxt;
        // carry here is the carry into the MSB
        ovf  <= carry ^ c_nxt;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder, WIDTH=8.
// Random and directed operations against an arithmetic model.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         sub = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  function automatic logic [10:0] model(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         s
  );
    int unsigned  r;
    int           sa;
    int           sb;
    int           sr;
    logic [W-1:0] rs;
    logic         c;
    logic         o;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (s) begin
      r  = (int'(a) - int'(b)) & 32'hFF;
      c  = (a >= b);
      sr = sa - sb;
    end else begin
      r  = int'(a) + int'(b);
      c  = (r > 255);
      sr = sa + sb;
    end
    rs = r[W-1:0];
    o  = (sr > 127) || (sr < -128);
    return {1'b0, o, c, rs};
  endfunction

  task automatic do_op(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         s,
    output logic [W-1:0] rs,
    output logic         rc,
    output logic         ro,
    output int           lat,
    output logic         bz,
    output logic         dz,
    output int           ovl
  );
    @(negedge clk);
    a_in = a; b_in = b; sub = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a_in = W'($urandom); b_in = W'($urandom);
    sub = 1'($urandom);
    bz = busy; lat = -1; ovl = 0;
    rs = 'x; rc = 1'bx; ro = 1'bx;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (busy && done) ovl++;
      if (done) begin
        lat = i; rs = sum; rc = cout; ro = ovf;
        break;
      end
    end
    @(posedge clk); #1;
    dz = done;
  endtask

  task automatic check_op(
    input string         nm,
    input logic [W-1:0]  a,
    input logic [W-1:0]  b,
    input logic          s
  );
    logic [W-1:0] rs;
    logic         rc, ro, bz, dz;
    int           lat, ovl;
    logic [10:0]  m;
    m = model(a, b, s);
    do_op(a, b, s, rs, rc, ro, lat, bz, dz, ovl);
    n_cmp++;
    if (lat !== W) begin
      n_err++;
      $display("FAIL %s latency got %0d want %0d", nm, lat, W);
    end
    n_cmp++;
    if ({ro, rc, rs} !== m[9:0]) begin
      n_err++;
      $display("FAIL %s %h op %h s=%b got ovf/cout/sum %b/%b/%h want %b/%b/%h",
               nm, a, b, s, ro, rc, rs, m[9], m[8], m[7:0]);
    end
    n_cmp++;
    if (bz !== 1'b1 || dz !== 1'b0 || ovl !== 0) begin
      n_err++;
      $display("FAIL %s handshake busy=%b done_after=%b overlap=%0d want 1/0/0",
               nm, bz, dz, ovl);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, sum, cout, ovf} !== '0) begin
      n_err++;
      $display("FAIL reset_state got %b/%b/%h/%b/%b want all 0",
               busy, done, sum, cout, ovf);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_op("after_reset", 8'h12, 8'h34, 1'b0);
  endtask

  task automatic test_vectors;
    check_op("v35_4a", 8'h35, 8'h4A, 1'b0);
    check_op("vff_01", 8'hFF, 8'h01, 1'b0);
    check_op("v7f_01", 8'h7F, 8'h01, 1'b0);
    check_op("v80_80", 8'h80, 8'h80, 1'b0);
  endtask

  task automatic test_random;
    logic s;
    for (int i = 0; i < 20; i++) begin
`ifdef SERIAL_ADDER_SUB_EN
      s = 1'($urandom);
`else
      s = 1'b0;
`endif
      check_op("random", W'($urandom), W'($urandom), s);
    end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    a_in = W'($urandom); b_in = W'($urandom);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    a_in = W'($urandom); b_in = W'($urandom);
    start = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, sum, cout, ovf} !== '0) begin
      n_err++;
      $display("FAIL async_reset got %b/%b/%h/%b/%b want all 0",
               busy, done, sum, cout, ovf);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL rst_beats_start busy got %b want 0", busy);
    end
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    check_op("post_async", 8'hC3, 8'h5A, 1'b0);
  endtask

  task automatic test_abort;
    int dn;
    @(negedge clk);
    a_in = 8'hAA; b_in = 8'h55; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    n_cmp++;
    if (dn !== 0) begin
      n_err++;
      $display("FAIL abort_no_done got %0d pulses want 0", dn);
    end
    check_op("abort_next", 8'h0F, 8'h01, 1'b0);
  endtask

  task automatic test_back_to_back;
    int pos[$];
    int ovl;
    ovl = 0;
    @(negedge clk);
    a_in = 8'h01; b_in = 8'h02; sub = 1'b0; start = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk); #1;
      if (busy && done) ovl++;
      if (done) begin
        pos.push_back(i);
        n_cmp++;
        if (sum !== 8'h03) begin
          n_err++;
          $display("FAIL b2b_sum got %h want 03", sum);
        end
      end
    end
    start = 1'b0;
    n_cmp++;
    if (pos.size() !== 5 || ovl !== 0) begin
      n_err++;
      $display("FAIL b2b_count got %0d dones overlap %0d want 5/0",
               pos.size(), ovl);
    end
    for (int j = 0; j < pos.size(); j++) begin
      n_cmp++;
      if (pos[j] !== W + 1 + 10 * j) begin
        n_err++;
        $display("FAIL b2b_pos %0d got edge %0d want %0d",
                 j, pos[j], W + 1 + 10 * j);
      end
    end
    repeat (12) @(posedge clk);
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub;
    check_op("sub10_20", 8'h10, 8'h20, 1'b1);
    check_op("sub80_01", 8'h80, 8'h01, 1'b1);
    check_op("sub55_55", 8'h55, 8'h55, 1'b1);
  endtask
`endif

  initial begin
    #1;
    test_reset();
    test_vectors();
    test_random();
    test_async_reset();
    test_abort();
    test_back_to_back();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder (optional subtractor) built around the team's single-bit half/full adder cell: one operand bit pair per clock, LSB first, with a registered carry between cycles. It is the sequential counterpart to the combinational adder cells and sits wherever area matters more than latency. A start/busy/done handshake means a controller or bench can issue operations and collect results without tracking cycle counts.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock; the single clock of the block.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request an operation; sampled only in IDLE.
- a_in  input  WIDTH  operand A; captured on the accepting edge.
- b_in  input  WIDTH  operand B; captured on the accepting edge.
- sub  input  1  0 = add, 1 = subtract; present only with SERIAL_ADDER_SUB_EN.
- busy  output  1  high while bits are being processed (SHIFT).
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  result, held until the next accepted start.
- cout  output  1  carry out of the MSB (add), or no-borrow (subtract).
- ovf  output  1  two's-complement signed overflow.

## Operation
- Single clock, one asynchronous active-high reset.
- Internal state: a_sh, b_sh (WIDTH-bit shift registers), res_sh (WIDTH bits), carry flop, bit counter cnt ($clog2(WIDTH) bits), state.
- FSM states and transitions:
  - IDLE: if start=1, go to SHIFT. Otherwise stay.
  - SHIFT: go to DONE after the WIDTH-th bit. Otherwise stay.
  - DONE: go to IDLE unconditionally.
- On an accepted start:
  - Load a_sh=a_in.
  - Load b_sh=b_in, or ~b_in when subtracting.
  - Set carry=0 for add, 1 for subtract.
  - Clear cnt=0.
- Each SHIFT edge:
  - s = a_sh[0]^b_sh[0]^carry.
  - carry <= majority(a_sh[0], b_sh[0], carry).
  - res_sh shifts right, with s inserted at the MSB.
  - a_sh and b_sh shift right.
  - cnt increments.
- On the last SHIFT edge (cnt=WIDTH-1):
  - sum <= final res_sh.
  - cout <= final carry.
  - ovf <= carry into the MSB XOR carry out of the MSB.
  - done <= 1.
- start is ignored in SHIFT and DONE. There is no queuing; the requester must re-assert start in IDLE.
- a_in, b_in and sub may change freely after the accepting edge.

## Timing
- Reset value of every output is 0: busy, done, sum, cout, ovf. State returns to IDLE and all internal registers clear.
- If start is sampled at edge k:
  - busy=1 after edge k.
  - Bits are processed on edges k+1 .. k+WIDTH.
  - done=1 and results are valid after edge k+WIDTH; busy=0 at that point.
  - done=0 after edge k+WIDTH+1, and the FSM is back in IDLE.
- Latency from the start edge to done is WIDTH cycles. Minimum issue interval is WIDTH+2 cycles; the earliest next start is sampled at edge k+WIDTH+2.
- sum, cout and ovf are stable from the done pulse until the SHIFT entry of the next operation.
- busy and done are never high together.
- Reset mid-operation aborts immediately and asynchronously. All outputs go to 0, and no done is emitted for the aborted operation.
- If start and rst are asserted together, rst wins and start is dropped.

## Configuration
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - The sub port exists.
  - sub=1 computes a_in - b_in as a_in + ~b_in + 1.
  - cout=1 means no borrow (a_in >= b_in, unsigned).
  - ovf flags signed overflow of the subtraction.
- Undefined:
  - No sub port.
  - b is never inverted and carry always initialises to 0, giving add only.

## Test plan
- rst=1 mid-stream with random inputs -> busy=done=sum=cout=ovf=0 immediately; the first start after release is accepted normally.
- WIDTH=8, 8'h35+8'h4A -> done pulses for exactly one cycle 8 edges after the start edge; sum=8'h7F, cout=0, ovf=0.
- 8'hFF+8'h01 -> sum=8'h00, cout=1, ovf=0. Then 8'h7F+8'h01 -> sum=8'h80, cout=0, ovf=1.
- start held high continuously with 8'h01+8'h02 -> exactly one done per 10 cycles; start is ignored during busy; sum=8'h03 each time.
- Assert rst 4 edges into an operation -> no done pulse; the next operation 8'h0F+8'h01 gives sum=8'h10.
- With SERIAL_ADDER_SUB_EN: 8'h10-8'h20 -> sum=8'hF0, cout=0; 8'h80-8'h01 -> sum=8'h7F, cout=1, ovf=1.
